// File: rtl/heap_responder_if.sv
// rtl/heap_responder_if.sv - word-fetch bus between the core and the heap responder
// The core drives request fields; the responder returns busy, the response pulse and data.
interface heap_responder_if;
    logic        req;
    logic        we;
    logic [15:0] addr_in;
    logic [15:0] wdata;
    logic        busy;
    logic        data_ready;
    logic [15:0] data_out;
    logic        err;

    modport master (
        output req, we, addr_in, wdata,
        input  busy, data_ready, data_out, err
    );

    modport slave (
        input  req, we, addr_in, wdata,
        output busy, data_ready, data_out, err
    );
endinterface

// File: rtl/heap_responder.sv
// rtl/heap_responder.sv - Lisp heap responder with fixed latency and post-reset clear
// One request at a time; responses are registered and appear exactly LATENCY cycles after acceptance.
module heap_responder #(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 2,
    parameter logic [15:0] NIL_WORD  = 16'h0000,
    parameter logic [15:0] RANGE_ERR = 16'hAAAA
) (
    input  logic              clk,
    input  logic              rst,
    heap_responder_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_IDLE    = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt;
    logic            r_we;
    logic [15:0]     r_addr;
    logic [15:0]     r_wdata;
    logic            r_data_ready;
    logic            r_err;
    logic [15:0]     r_data_out;
    logic [15:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_enter_respond;
    logic            w_cur_we;
    logic [15:0]     w_cur_addr;
    logic [15:0]     w_cur_wdata;
    logic            w_in_range;
    logic [AW-1:0]   w_idx;

    // With LATENCY=1 the response edge is the acceptance edge, so the live bus fields are used.
    assign w_accept    = (r_state == S_IDLE) && bus.req;
    assign w_cur_we    = (r_state == S_IDLE) ? bus.we      : r_we;
    assign w_cur_addr  = (r_state == S_IDLE) ? bus.addr_in : r_addr;
    assign w_cur_wdata = (r_state == S_IDLE) ? bus.wdata   : r_wdata;
    assign w_in_range  = ({16'd0, w_cur_addr} < 32'(DEPTH));
    assign w_idx       = w_in_range ? w_cur_addr[AW-1:0] : '0;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:    if (r_ptr == AW'(DEPTH - 1)) w_next_state = S_IDLE;
            S_IDLE:    if (bus.req) w_next_state = (LATENCY == 1) ? S_RESPOND : S_WAIT;
            S_WAIT:    if (r_cnt == CW'(1)) w_next_state = S_RESPOND;
            S_RESPOND: w_next_state = S_IDLE;
            default:   w_next_state = S_INIT;
        endcase
    end

    assign w_enter_respond = (w_next_state == S_RESPOND) && (r_state != S_RESPOND);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_INIT;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_data_ready <= 1'b0;
            r_err        <= 1'b0;
            r_data_out   <= NIL_WORD;
        end else begin
            r_state      <= w_next_state;
            r_data_ready <= w_enter_respond;
            r_err        <= w_enter_respond && !w_in_range;
            if (r_state == S_INIT) begin
                r_ptr <= r_ptr + AW'(1);
            end
            if (w_accept) begin
                r_we    <= bus.we;
                r_addr  <= bus.addr_in;
                r_wdata <= bus.wdata;
                r_cnt   <= CW'(LATENCY - 1);
            end else if (r_state == S_WAIT) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (w_enter_respond) begin
                if (!w_in_range) begin
                    r_data_out <= RANGE_ERR;
                end else if (w_cur_we) begin
                    r_data_out <= w_cur_wdata;
                end else begin
                    r_data_out <= r_mem[w_idx];
                end
            end
        end
    end

    // The heap array itself has no reset; INIT clears it one word per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (r_state == S_INIT) begin
                r_mem[r_ptr] <= NIL_WORD;
            end else if (w_enter_respond && w_cur_we && w_in_range) begin
                r_mem[w_idx] <= w_cur_wdata;
            end
        end
    end

    assign bus.busy       = (r_state != S_IDLE);
    assign bus.data_ready = r_data_ready;
    assign bus.data_out   = r_data_out;
    assign bus.err        = r_err;
endmodule
